fifo_stream_drain: RTL
======================

Name: fifo_stream_drain

Overview:
- Drains the synchronous data FIFO and presents its contents as a registered valid/ready stream.
- Sits directly downstream of the FIFO: it watches the FIFO's empty flag and issues read strobes against the FIFO's combinational read-data output.
- Tags every PKTLEN-th word as the last word of a packet.
- Uses a one-entry skid register, so the FIFO read strobe never depends combinationally on downstream ready. Full throughput of one word per clock.

Parameters:
- BW, 8: data width; must match the upstream FIFO width.
- PKTLEN, 4: words per packet; legal range 1..256.
- LGPKT, 8: width of the packet word counter; must satisfy 2^LGPKT >= PKTLEN.

Ports:
- i_clk  input  1  clock, all state updates on rising edge
- i_reset  input  1  asynchronous active-high reset
- i_fifo_empty  input  1  FIFO empty flag
- i_fifo_data  input  BW  FIFO read data; valid combinationally at the current read address
- o_fifo_rd  output  1  FIFO read strobe; consumes i_fifo_data at this clock edge
- o_valid  output  1  output word valid
- i_ready  input  1  downstream accepts the word when o_valid && i_ready
- o_data  output  BW  output word
- o_last  output  1  word is the final word of a packet; meaningful only while o_valid

Behaviour:
- Reset: asynchronous; clears o_valid, o_last, o_data (all 0), the skid register (valid, data, last) and the word counter.
- o_fifo_rd is combinationally forced to 0 while i_reset is high.
- Reset mid-packet discards buffered words; the word counter restarts at 0.
- Read strobe: o_fifo_rd = !i_reset && !i_fifo_empty && !skid_valid. It is never asserted while i_fifo_empty=1.
- Load path, at an edge where o_fifo_rd=1, the FIFO word and its tag (tag = counter==PKTLEN-1) go to:
  - the output register if !o_valid || i_ready;
  - otherwise the skid register (output stalled).
- Skid drain: at an edge where skid_valid && (!o_valid || i_ready), the skid contents move to the output register and skid_valid clears. This cannot coincide with a FIFO load, because o_fifo_rd=0 while skid_valid.
- Idle: at an edge with o_valid && i_ready and nothing to load, o_valid falls to 0.
- Stall rule: while o_valid && !i_ready, o_data and o_last hold stable and o_valid stays 1.
- Latency: a word read at edge k appears on o_data/o_valid after edge k (1 cycle), provided the output is free or accepted at k.
- Word counter: increments on each FIFO read. It wraps to 0 after the read tagged last (counter==PKTLEN-1). With PKTLEN=1 every word is last.
- Ordering: words leave in exactly FIFO order; none are dropped or duplicated.
- Stream occupancy is at most 2 words (output + skid).
- Simultaneous events:
  - accept and load in the same edge: the new word replaces the accepted one, o_valid stays 1.
  - accept with skid full: the skid word moves out; o_fifo_rd resumes the next cycle.
- i_ready is allowed while !o_valid and has no effect.
- No combinational path from i_ready to o_fifo_rd.

Test Plan:
- Reset: hold i_reset=1 with i_fifo_empty=0 -> o_fifo_rd=0, o_valid=0, o_last=0, o_data=0. Deassert -> o_fifo_rd=1 in the next cycle.
- Streaming: FIFO preloaded with 0x10..0x17, i_ready=1 constant, PKTLEN=4 -> one word per cycle, 0x10..0x17 in order. o_last=1 only on 0x13 and 0x17.
- Backpressure: preload 0x20..0x23, i_ready=0 for 5 cycles:
  - o_valid=1, o_data=0x20 stable;
  - exactly 2 FIFO reads, then o_fifo_rd=0;
  - on release, 0x20,0x21,0x22,0x23 delivered in consecutive cycles.
- Underflow gaps: FIFO supplies a word every third cycle, i_ready=1 -> o_valid pulses 1 cycle per word. Counter spans the gaps; the 4th word has o_last=1.
- Mid-packet reset: after 2 words of a packet, pulse i_reset for 1 cycle, then stream 0x30..0x33 -> o_last=1 on 0x33 only, with no stale words emitted.
- Random: random i_ready and FIFO empty patterns over 10k cycles with scoreboard -> exact order, o_data/o_last stable under stall, o_last every 4th word.

Source files
------------

// File: rtl/fifo_stream_drain.sv
// Drains a synchronous FIFO into a registered valid/ready stream, tagging every
// PKTLEN-th word as last. A one-entry skid keeps the FIFO read independent of i_ready.
module fifo_stream_drain #(
    parameter int BW     = 8,
    parameter int PKTLEN = 4,
    parameter int LGPKT  = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_fifo_empty,
    input  logic [BW-1:0] i_fifo_data,
    output logic          o_fifo_rd,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [BW-1:0] o_data,
    output logic          o_last
);

    logic             skid_vld;
    logic [BW-1:0]    skid_data;
    logic             skid_last;
    logic [LGPKT-1:0] word_cnt;
    logic             tag;
    logic             out_free;

    assign tag       = (word_cnt == LGPKT'(PKTLEN - 1));
    // The skid occupancy alone throttles reads, so i_ready never reaches o_fifo_rd.
    assign o_fifo_rd = !i_reset && !i_fifo_empty && !skid_vld;
    assign out_free  = !o_valid || i_ready;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            word_cnt  <= '0;
            skid_vld  <= 1'b0;
            skid_data <= '0;
            skid_last <= 1'b0;
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_last    <= 1'b0;
        end else begin
            if (o_fifo_rd)
                word_cnt <= tag ? '0 : word_cnt + LGPKT'(1);

            // Output stage: skid word has priority; it cannot coincide with a FIFO read.
            if (out_free) begin
                if (skid_vld) begin
                    o_valid  <= 1'b1;
                    o_data   <= skid_data;
                    o_last   <= skid_last;
                    skid_vld <= 1'b0;
                end else if (o_fifo_rd) begin
                    o_valid <= 1'b1;
                    o_data  <= i_fifo_data;
                    o_last  <= tag;
                end else begin
                    o_valid <= 1'b0;
                end
            end else if (o_fifo_rd) begin
                skid_vld  <= 1'b1;
                skid_data <= i_fifo_data;
                skid_last <= tag;
            end
        end
    end

endmodule
